// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 receive-only slave delivering DATA_W-bit words on a valid/ready port.
// Define SPI_RX_SYNC_EN to add two-flop synchronizers on spi_CS, spi_sclk and spiData.
module spi_slave_rx #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_CS,
  input  logic              spi_sclk,
  input  logic              spiData,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [4:0]        bit_cnt,
  output logic              frame_err,
  output logic              overrun
);
`ifdef SPI_RX_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 1;
`endif
  typedef enum logic [1:0] {IDLE, RECV, WAIT_CS} state_t;
  state_t state_q, state_d;
  logic [SD:0] cs_q, cs_d, sclk_q, sclk_d, vld_q, vld_d;
  logic [SD-1:0] sdi_q, sdi_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic cs_cur, cs_rise, cs_fall, sclk_rise, sdi_cur;
  // Top bit of each pipe is the "previous" sample used for edge detection.
  always_comb begin
    cs_d   = {cs_q[SD-1:0], spi_CS};
    sclk_d = {sclk_q[SD-1:0], spi_sclk};
    vld_d  = {vld_q[SD-1:0], 1'b1};
    sdi_d  = SD'({sdi_q, spiData});
  end
  assign cs_cur    = cs_q[SD-1];
  assign cs_rise   = cs_cur & ~cs_q[SD];
  // A fall seen against the reset value of the pipe is not a real frame start.
  assign cs_fall   = ~cs_cur & cs_q[SD] & vld_q[SD];
  assign sclk_rise = sclk_q[SD-1] & ~sclk_q[SD];
  assign sdi_cur   = sdi_q[SD-1];
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q & ~data_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = RECV;
          bit_cnt_d = 5'd0;
          shift_d   = '0;
        end else if (~cs_cur) begin
          state_d = WAIT_CS;
        end
      end
      RECV: begin
        if (cs_rise) begin
          state_d     = IDLE;
          bit_cnt_d   = 5'd0;
          frame_err_d = bit_cnt_q != 5'd0;
        end else if (sclk_rise) begin
          shift_d   = (DATA_W-1)'({shift_q, sdi_cur});
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(DATA_W - 1)) begin
            data_d    = {shift_q, sdi_cur};
            valid_d   = 1'b1;
            overrun_d = valid_q & ~data_ready;
            state_d   = WAIT_CS;
          end
        end
      end
      WAIT_CS: begin
        if (cs_rise) begin
          state_d   = IDLE;
          bit_cnt_d = 5'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cs_q        <= '1;
      sclk_q      <= '0;
      vld_q       <= '0;
      sdi_q       <= '0;
      bit_cnt_q   <= 5'd0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      sclk_q      <= sclk_d;
      vld_q       <= vld_d;
      sdi_q       <= sdi_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign bit_cnt    = bit_cnt_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed frames with hand-computed expectations for spi_slave_rx.
module tb_spi_slave_rx;
  localparam int HALF = 4;
`ifdef SPI_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0, reset = 1'b0, spi_CS = 1'b1, spi_sclk = 1'b0, spiData = 1'b0, data_ready = 1'b0;
  logic [15:0] data_out;
  logic data_valid, frame_err, overrun;
  logic [4:0] bit_cnt;
  int n_chk = 0, n_pass = 0;
  int fe_n = 0, ov_n = 0, dv_n = 0;
  int fe0, ov0, dv0;
  always #5 clk = ~clk;
  spi_slave_rx #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .spi_CS(spi_CS), .spi_sclk(spi_sclk), .spiData(spiData),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .bit_cnt(bit_cnt), .frame_err(frame_err), .overrun(overrun)
  );
  always @(posedge clk) begin
    #1;
    fe_n <= fe_n + int'(frame_err);
    ov_n <= ov_n + int'(overrun);
    dv_n <= dv_n + int'(data_valid);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic snap();
    fe0 = fe_n;
    ov0 = ov_n;
    dv0 = dv_n;
  endtask
  task automatic spi_bit(input logic b);
    spiData = b;
    tick(HALF);
    spi_sclk = 1'b1;
    tick(HALF);
    spi_sclk = 1'b0;
  endtask
  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 15; i > 15 - n; i--) spi_bit(w[i]);
  endtask
  task automatic frame(input logic [15:0] w);
    spi_CS = 1'b0;
    tick(HALF);
    send_bits(w, 16);
    tick(HALF);
    spi_CS = 1'b1;
    tick(8);
  endtask
  task automatic word_to_edge(input logic [15:0] w);
    spi_CS = 1'b0;
    tick(HALF);
    send_bits(w, 15);
    spiData = w[0];
    tick(HALF);
    spi_sclk = 1'b1;
    tick(LAT - 1);
  endtask
  task automatic word_finish();
    tick(HALF);
    spi_sclk = 1'b0;
    tick(HALF);
    spi_CS = 1'b1;
    tick(8);
  endtask
  initial begin
    tick(2);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_bitcnt", 32'(bit_cnt), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    reset = 1'b1;
    tick(6);
    data_ready = 1'b1;
    snap();
    frame(16'hA569);
    check("a569_data", 32'(data_out), 32'hA569);
    check("a569_vcyc", 32'(dv_n - dv0), 32'd1);
    check("a569_ferr", 32'(fe_n - fe0), 32'd0);
    check("a569_ovr", 32'(ov_n - ov0), 32'd0);
    check("a569_vlow", 32'(data_valid), 32'h0);
    data_ready = 1'b0;
    snap();
    word_to_edge(16'h2563);
    check("lat_before", 32'(data_valid), 32'h0);
    tick(1);
    check("lat_at", 32'(data_valid), 32'h1);
    word_finish();
    frame(16'h9B63);
    check("ovr_pulse", 32'(ov_n - ov0), 32'd1);
    check("ovr_data", 32'(data_out), 32'h9B63);
    check("ovr_valid", 32'(data_valid), 32'h1);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    tick(1);
    check("accept_clr", 32'(data_valid), 32'h0);
    snap();
    spi_CS = 1'b0;
    tick(HALF);
    send_bits(16'h6A61, 7);
    tick(2);
    check("part_bitcnt", 32'(bit_cnt), 32'd7);
    spi_CS = 1'b1;
    tick(8);
    check("part_ferr", 32'(fe_n - fe0), 32'd1);
    check("part_valid", 32'(data_valid), 32'h0);
    check("part_data", 32'(data_out), 32'h9B63);
    check("part_bitcnt0", 32'(bit_cnt), 32'd0);
    data_ready = 1'b1;
    snap();
    spi_CS = 1'b0;
    tick(HALF);
    send_bits(16'hA265, 16);
    spi_bit(1'b1);
    spi_bit(1'b0);
    tick(2);
    check("xtra_bitcnt", 32'(bit_cnt), 32'd16);
    spi_CS = 1'b1;
    tick(8);
    check("xtra_data", 32'(data_out), 32'hA265);
    check("xtra_bitcnt0", 32'(bit_cnt), 32'd0);
    check("xtra_ferr", 32'(fe_n - fe0), 32'd0);
    data_ready = 1'b0;
    frame(16'h0F0F);
    snap();
    word_to_edge(16'h1234);
    check("coin_pre_valid", 32'(data_valid), 32'h1);
    check("coin_pre_data", 32'(data_out), 32'h0F0F);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    check("coin_valid", 32'(data_valid), 32'h1);
    check("coin_data", 32'(data_out), 32'h1234);
    word_finish();
    check("coin_ovr", 32'(ov_n - ov0), 32'd0);
    check("coin_hold", 32'(data_valid), 32'h1);
    spi_CS = 1'b0;
    tick(HALF);
    send_bits(16'hC3A5, 8);
    reset = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_valid", 32'(data_valid), 32'h0);
    tick(2);
    reset = 1'b1;
    snap();
    send_bits(16'hA500, 8);
    tick(HALF);
    spi_CS = 1'b1;
    tick(8);
    check("broken_vcyc", 32'(dv_n - dv0), 32'd0);
    check("broken_data", 32'(data_out), 32'h0);
    check("broken_ferr", 32'(fe_n - fe0), 32'd0);
    frame(16'h7564);
    check("after_data", 32'(data_out), 32'h7564);
    check("after_valid", 32'(data_valid), 32'h1);
    check("after_ovr", 32'(ov_n - ov0), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
